// File: rtl/cpu_bus_arbiter.sv
// Shares the CPU memory bus between the debug UART master and the DMA engine by halting the CPU.
// Optional grant watchdog: define BUS_ARB_WDOG_EN.
module cpu_bus_arbiter #(
  parameter int HALT_TIMEOUT = 255,
  parameter int WDOG_CYCLES  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbg_req,
  output logic        dbg_gnt,
  input  logic [15:0] dbg_addr,
  input  logic [7:0]  dbg_wdata,
  input  logic        dbg_we,
  input  logic        dbg_re,
  input  logic        dma_req,
  output logic        dma_gnt,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_we,
  input  logic        dma_re,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_we,
  output logic        bus_re,
  input  logic [7:0]  bus_rdata,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        cpu_halt,
  input  logic        cpu_is_halted,
  output logic        halt_err,
  output logic        wdog_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HALT_WAIT = 3'd1,
    GRANT_DBG = 3'd2,
    GRANT_DMA = 3'd3,
    RELEASE   = 3'd4
  } state_t;

  localparam int HCW = $clog2(HALT_TIMEOUT + 1);
  localparam logic [HCW-1:0] HALT_MAX  = HCW'(HALT_TIMEOUT);
  localparam logic [HCW-1:0] HALT_LAST = HCW'(HALT_TIMEOUT - 1);

  state_t         state_reg, state_next;
  logic [HCW-1:0] hcnt_reg, hcnt_next;
  logic           halt_err_reg, halt_err_next;
  logic           from_dbg_reg, from_dbg_next;
  logic [7:0]     rd_data_reg;
  logic           rd_valid_reg;

  logic dbg_req_eff;
  logic dma_req_eff;
  logic wdog_fire;

`ifdef BUS_ARB_WDOG_EN
  localparam int WCW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WCW-1:0] WDOG_LAST = WCW'(WDOG_CYCLES - 1);

  logic [WCW-1:0] wcnt_reg;
  logic           wdog_err_reg;
  logic           dbg_lock_reg;
  logic           dma_lock_reg;
  logic           granted;
  logic           own_req;
  logic           own_strobe;

  assign granted    = (state_reg == GRANT_DBG) || (state_reg == GRANT_DMA);
  assign own_req    = (state_reg == GRANT_DBG) ? dbg_req : dma_req;
  assign own_strobe = (state_reg == GRANT_DBG) ? (dbg_we | dbg_re) : (dma_we | dma_re);
  assign wdog_fire  = granted && own_req && !own_strobe && (wcnt_reg == WDOG_LAST);

  // A revoked master stays locked out until it has dropped req for a cycle.
  assign dbg_req_eff = dbg_req && !dbg_lock_reg;
  assign dma_req_eff = dma_req && !dma_lock_reg;
  assign wdog_err    = wdog_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_reg     <= '0;
      wdog_err_reg <= 1'b0;
      dbg_lock_reg <= 1'b0;
      dma_lock_reg <= 1'b0;
    end else begin
      wdog_err_reg <= wdog_fire;
      dbg_lock_reg <= (wdog_fire && state_reg == GRANT_DBG) || (dbg_lock_reg && dbg_req);
      dma_lock_reg <= (wdog_fire && state_reg == GRANT_DMA) || (dma_lock_reg && dma_req);
      if (!granted || own_strobe || wdog_fire) begin
        wcnt_reg <= '0;
      end else begin
        wcnt_reg <= wcnt_reg + WCW'(1);
      end
    end
  end
`else
  // Never fires; the parameter stays referenced so both builds share one interface.
  assign wdog_fire   = (WDOG_CYCLES < 0);
  assign dbg_req_eff = dbg_req;
  assign dma_req_eff = dma_req;
  assign wdog_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      hcnt_reg     <= '0;
      halt_err_reg <= 1'b0;
      from_dbg_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hcnt_reg     <= hcnt_next;
      halt_err_reg <= halt_err_next;
      from_dbg_reg <= from_dbg_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hcnt_next     = hcnt_reg;
    halt_err_next = halt_err_reg;
    from_dbg_next = from_dbg_reg;
    case (state_reg)
      IDLE: begin
        if (dbg_req_eff || dma_req_eff) begin
          state_next = HALT_WAIT;
          hcnt_next  = '0;
        end
      end
      HALT_WAIT: begin
        if (!dbg_req_eff && !dma_req_eff) begin
          state_next = IDLE;
        end else if (cpu_is_halted) begin
          state_next = dbg_req_eff ? GRANT_DBG : GRANT_DMA;
        end else if (hcnt_reg != HALT_MAX) begin
          hcnt_next = hcnt_reg + HCW'(1);
          if (hcnt_reg == HALT_LAST) begin
            halt_err_next = 1'b1;
          end
        end
      end
      GRANT_DBG: begin
        if (!cpu_is_halted) begin
          halt_err_next = 1'b1;
        end
        if (!dbg_req || wdog_fire) begin
          state_next    = RELEASE;
          from_dbg_next = 1'b1;
        end
      end
      GRANT_DMA: begin
        if (!cpu_is_halted) begin
          halt_err_next = 1'b1;
        end
        if (!dma_req || wdog_fire) begin
          state_next    = RELEASE;
          from_dbg_next = 1'b0;
        end
      end
      RELEASE: begin
        // Hand the bus straight to the waiting master without letting the CPU run.
        if (from_dbg_reg && dma_req_eff && cpu_is_halted) begin
          state_next = GRANT_DMA;
        end else if (!from_dbg_reg && dbg_req_eff && cpu_is_halted) begin
          state_next = GRANT_DBG;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dbg_gnt   = (state_reg == GRANT_DBG);
    dma_gnt   = (state_reg == GRANT_DMA);
    cpu_halt  = (state_reg != IDLE);
    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    bus_re    = 1'b0;
    if (dbg_gnt && cpu_is_halted) begin
      bus_addr  = dbg_addr;
      bus_wdata = dbg_wdata;
      bus_we    = dbg_we;
      bus_re    = dbg_re && !dbg_we;
    end else if (dma_gnt && cpu_is_halted) begin
      bus_addr  = dma_addr;
      bus_wdata = dma_wdata;
      bus_we    = dma_we;
      bus_re    = dma_re && !dma_we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= bus_re;
      if (bus_re) begin
        rd_data_reg <= bus_rdata;
      end
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign halt_err = halt_err_reg;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: directed scenarios plus random traffic against a cycle-level ownership model.
module tb_cpu_bus_arbiter;

  localparam int HT = 255;
  localparam int WD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbg_req, dbg_we, dbg_re, dma_req, dma_we, dma_re;
  logic [15:0] dbg_addr, dma_addr;
  logic [7:0]  dbg_wdata, dma_wdata;
  logic        dbg_gnt, dma_gnt;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata, rd_data;
  logic        bus_we, bus_re, rd_valid, cpu_halt, cpu_is_halted, halt_err, wdog_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpu_bus_arbiter #(.HALT_TIMEOUT(HT), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst),
    .dbg_req(dbg_req), .dbg_gnt(dbg_gnt), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_we(dbg_we), .dbg_re(dbg_re),
    .dma_req(dma_req), .dma_gnt(dma_gnt), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_we(dma_we), .dma_re(dma_re),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .rd_data(rd_data), .rd_valid(rd_valid),
    .cpu_halt(cpu_halt), .cpu_is_halted(cpu_is_halted),
    .halt_err(halt_err), .wdog_err(wdog_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: who owns the bus, who just gave it up, and whether the CPU is held.
  int         m_owner;   // 0 nobody, 1 debug, 2 dma
  int         m_freed;   // master that gave the bus up last cycle (0 none)
  bit         m_halt, m_herr, m_rdv, m_wdp;
  int         m_wait, m_wd;
  logic [7:0] m_rdd;
  bit [2:0]   m_lock;

  task automatic model_reset();
    m_owner = 0; m_freed = 0; m_halt = 0; m_herr = 0; m_rdv = 0; m_wdp = 0;
    m_wait = 0; m_wd = 0; m_rdd = 8'h00; m_lock = '0;
  endtask

  always @(negedge clk) begin
    bit [2:0]    raw, eff;
    bit          we_e, re_e, strobe;
    logic [15:0] a_e;
    logic [7:0]  d_e;
    if (rst) model_reset();
    raw  = {dma_req, dbg_req, 1'b0};
    eff  = raw & ~m_lock;
    a_e  = 16'h0; d_e = 8'h0; we_e = 0; re_e = 0;
    if (m_owner == 1 && cpu_is_halted) begin
      a_e = dbg_addr; d_e = dbg_wdata; we_e = dbg_we; re_e = dbg_re && !dbg_we;
    end else if (m_owner == 2 && cpu_is_halted) begin
      a_e = dma_addr; d_e = dma_wdata; we_e = dma_we; re_e = dma_re && !dma_we;
    end
    check("ctl", {dbg_gnt, dma_gnt, cpu_halt, halt_err, wdog_err},
          {m_owner == 1, m_owner == 2, m_halt, m_herr, m_wdp});
    check("bus", {bus_addr, bus_wdata, bus_we, bus_re}, {a_e, d_e, we_e, re_e});
    check("rd", {rd_valid, rd_data}, {m_rdv, m_rdd});
    if (!rst) begin
      m_rdv = re_e;
      if (re_e) m_rdd = bus_rdata;
      m_wdp  = 0;
      m_lock = m_lock & raw;
      if (m_owner != 0) begin
        strobe = (m_owner == 1) ? (dbg_we || dbg_re) : (dma_we || dma_re);
        if (!cpu_is_halted) m_herr = 1;
        if (!raw[m_owner]) begin
          m_freed = m_owner; m_owner = 0;
        end else begin
`ifdef BUS_ARB_WDOG_EN
          if (strobe) m_wd = 0;
          else if (m_wd + 1 == WD) begin
            m_lock[m_owner] = 1'b1; m_wdp = 1; m_freed = m_owner; m_owner = 0;
          end else m_wd++;
`endif
        end
      end else if (m_freed != 0) begin
        if (eff[3 - m_freed] && cpu_is_halted) begin
          m_owner = 3 - m_freed; m_wd = 0;
        end else m_halt = 0;
        m_freed = 0;
      end else if (m_halt) begin
        if (eff == 0) m_halt = 0;
        else if (cpu_is_halted) begin
          m_owner = eff[1] ? 1 : 2; m_wd = 0;
        end else if (m_wait < HT) begin
          m_wait++;
          if (m_wait == HT) m_herr = 1;
        end
      end else if (eff != 0) begin
        m_halt = 1; m_wait = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dbg_req = 0; dbg_we = 0; dbg_re = 0; dbg_addr = 16'h0; dbg_wdata = 8'h0;
    dma_req = 0; dma_we = 0; dma_re = 0; dma_addr = 16'h0; dma_wdata = 8'h0;
    bus_rdata = 8'h0; cpu_is_halted = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    cyc(2);
    rst = 0;
    cyc(1);
  endtask

  initial begin
    do_reset();

    // Debug write; CPU acknowledges three cycles after the halt request.
    dbg_req = 1; dbg_addr = 16'h0200; dbg_wdata = 8'h5A; dbg_we = 1;
    @(negedge clk); check("wr_halt_n", cpu_halt, 0);
    cyc(1); @(negedge clk);
    check("wr_halt_n1", cpu_halt, 1); check("wr_nogrant_we", bus_we, 0);
    cyc(3); cpu_is_halted = 1;
    @(negedge clk); check("wr_gnt_m", dbg_gnt, 0);
    cyc(1); @(negedge clk);
    check("wr_gnt_m1", dbg_gnt, 1);
    check("wr_bus", {bus_we, bus_addr, bus_wdata}, {1'b1, 16'h0200, 8'h5A});
    cyc(1); dbg_we = 0; dbg_req = 0;
    cyc(1); @(negedge clk); check("wr_rel", {dbg_gnt, cpu_halt}, 2'b01);
    cyc(1); @(negedge clk); check("wr_unhalt", cpu_halt, 0);
    cpu_is_halted = 0;
    cyc(2);

    // DMA read.
    dma_req = 1; dma_addr = 16'h0300; dma_re = 1; bus_rdata = 8'hC3;
    cyc(1); cpu_is_halted = 1;
    cyc(1); @(negedge clk);
    check("rd_gnt", {dbg_gnt, dma_gnt}, 2'b01);
    check("rd_bus", {bus_re, bus_addr, rd_valid}, {1'b1, 16'h0300, 1'b0});
    cyc(1); dma_re = 0; @(negedge clk);
    check("rd_data", {rd_valid, rd_data}, {1'b1, 8'hC3});
    dma_req = 0;
    cyc(3); cpu_is_halted = 0;
    cyc(2);

    // Simultaneous requests: debug first, DMA follows with the CPU kept halted.
    dbg_req = 1; dma_req = 1;
    cyc(1); cpu_is_halted = 1;
    cyc(1); @(negedge clk); check("sim_dbg", {dbg_gnt, dma_gnt}, 2'b10);
    dbg_req = 0;
    cyc(1); @(negedge clk); check("sim_rel", {dbg_gnt, dma_gnt, cpu_halt}, 3'b001);
    cyc(1); @(negedge clk); check("sim_dma", {dbg_gnt, dma_gnt, cpu_halt}, 3'b011);
    dma_req = 0;
    cyc(2); @(negedge clk); check("sim_done", cpu_halt, 0);
    cpu_is_halted = 0;
    cyc(2);

    // Halt acknowledge timeout.
    dbg_req = 1; dbg_we = 1; dbg_addr = 16'h1234;
    cyc(1);
    cyc(HT - 1); @(negedge clk); check("to_before", halt_err, 0);
    cyc(1); @(negedge clk);
    check("to_set", {halt_err, dbg_gnt, bus_we}, 3'b100);
    cpu_is_halted = 1;
    cyc(1); @(negedge clk); check("to_grant", {halt_err, dbg_gnt}, 2'b11);
    dbg_req = 0; dbg_we = 0;
    cyc(3); cpu_is_halted = 0;
    cyc(2); @(negedge clk); check("to_sticky", halt_err, 1);

    // Asynchronous reset in the middle of a DMA read burst.
    dma_req = 1; dma_re = 1; dma_addr = 16'h0400; bus_rdata = 8'h77; cpu_is_halted = 1;
    cyc(3);
    #2 rst = 1;
    #1 check("rst_async", {dma_gnt, cpu_halt, bus_re, rd_valid, halt_err, rd_data},
             {5'b00000, 8'h00});
    cyc(1); rst = 0; idle_inputs();
    cyc(1); @(negedge clk); check("rst_idle", {dma_gnt, cpu_halt}, 2'b00);

    // Random traffic; every cycle is checked by the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      if ($urandom_range(9) == 0) dbg_req = ~dbg_req;
      if ($urandom_range(9) == 0) dma_req = ~dma_req;
      dbg_we = ($urandom_range(2) == 0); dbg_re = ($urandom_range(2) == 0);
      dma_we = ($urandom_range(2) == 0); dma_re = ($urandom_range(2) == 0);
      dbg_addr = 16'($urandom); dma_addr = 16'($urandom);
      dbg_wdata = 8'($urandom); dma_wdata = 8'($urandom); bus_rdata = 8'($urandom);
      if (cpu_halt) begin
        if (!cpu_is_halted && $urandom_range(2) == 0) cpu_is_halted = 1;
        else if (cpu_is_halted && $urandom_range(63) == 0) cpu_is_halted = 0;
      end else if ($urandom_range(1) == 0) cpu_is_halted = 0;
    end

`ifdef BUS_ARB_WDOG_EN
    do_reset();
    dbg_req = 1; cpu_is_halted = 1;
    cyc(2); @(negedge clk); check("wd_gnt", dbg_gnt, 1);
    cyc(WD - 1); @(negedge clk); check("wd_hold", {dbg_gnt, wdog_err}, 2'b10);
    cyc(1); @(negedge clk); check("wd_fire", {dbg_gnt, wdog_err, cpu_halt}, 3'b011);
    cyc(1); @(negedge clk); check("wd_after", {wdog_err, cpu_halt}, 2'b00);
    cyc(2); @(negedge clk); check("wd_lock", cpu_halt, 0);
    dbg_req = 0;
    cyc(1); dbg_req = 1;
    cyc(1); @(negedge clk); check("wd_rereq", cpu_halt, 1);
    cyc(3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
